// File: rtl/q_neuron_if.sv
// Handshake and weight-write bus of the q_neuron block.
// The master side feeds samples, writes weights and consumes results; the
// slave side is the neuron itself.
interface q_neuron_if #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8
);
  localparam int AW = $clog2(N_INPUTS + 1);

  // Sample stream into the neuron
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;

  // Weight / bias register file write port
  logic                     w_we;
  logic [AW-1:0]            w_addr;
  logic signed [DATA_W-1:0] w_data;

  // Result stream out of the neuron
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] value;

  modport master (
    output in_valid, in_data, w_we, w_addr, w_data, out_ready,
    input  in_ready, out_valid, value
  );

  modport slave (
    input  in_valid, in_data, w_we, w_addr, w_data, out_ready,
    output in_ready, out_valid, value
  );
endinterface

// File: rtl/q_neuron.sv
// Single sequential neuron: multiply-accumulates N_INPUTS signed Q-format
// samples against stored weights, then adds a bias, rounds half-up,
// optionally applies ReLU and saturates to DATA_W bits.
module q_neuron #(
  parameter int N_INPUTS  = 4,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int RELU      = 0
) (
  input  logic     clk,
  input  logic     reset,
  q_neuron_if.slave bus
);

  localparam int AW    = $clog2(N_INPUTS + 1);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W = 2 * DATA_W + AW;
  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MINV = -(SUM_W'(1) <<< (DATA_W - 1));

  typedef enum logic [1:0] {
    S_ACCUM,
    S_FINISH,
    S_OUT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [DATA_W-1:0] wt [N_INPUTS+1];

  logic signed [ACC_W-1:0]  acc_p0;
  logic [AW-1:0]            idx_p0;
  logic signed [DATA_W-1:0] value_p1;
  logic                     vld_p1;

  logic                     accept;
  logic signed [DATA_W-1:0] w_cur;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;

  // Half-up rounding: add half an output LSB, then drop the extra fraction bits
  function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [SUM_W-1:0] x);
    return (x + HALF) >>> FRAC_BITS;
  endfunction

  // Optional ReLU applied before saturation
  function automatic logic signed [SUM_W-1:0] activate(input logic signed [SUM_W-1:0] x);
    if ((RELU != 0) && x[SUM_W-1])
      return '0;
    return x;
  endfunction

  // Clamp to the representable DATA_W range
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] x);
    if (x > MAXV)
      return MAXV[DATA_W-1:0];
    if (x < MINV)
      return MINV[DATA_W-1:0];
    return x[DATA_W-1:0];
  endfunction

  assign accept = bus.in_valid && (state_q == S_ACCUM);
  assign w_cur  = wt[idx_p0];
  // Both operands are sign-extended to the full product width first
  assign prod   = PROD_W'(bus.in_data) * PROD_W'(w_cur);
  // Bias is aligned to the product's 2*FRAC_BITS fraction before adding
  assign sum    = SUM_W'(acc_p0) + (SUM_W'(wt[N_INPUTS]) <<< FRAC_BITS);

  assign bus.value     = value_p1;
  assign bus.out_valid = vld_p1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_ACCUM;
    else
      state_q <= state_d;
  end

  // Next-state logic; in_ready depends on state only
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    case (state_q)
      S_ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && (idx_p0 == AW'(N_INPUTS - 1)))
          state_d = S_FINISH;
      end
      S_FINISH: state_d = S_OUT;
      S_OUT: begin
        if (bus.out_ready)
          state_d = S_ACCUM;
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // Weight/bias register file; writes land in any state, reads see the old value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= N_INPUTS; i++)
        wt[i] <= '0;
    end else if (bus.w_we && (bus.w_addr <= AW'(N_INPUTS))) begin
      wt[bus.w_addr] <= bus.w_data;
    end
  end

  // Stage p0: accumulate one product per accepted sample
  // Stage p1: finalize result and hold it until the consumer takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p0   <= '0;
      idx_p0   <= '0;
      value_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (accept) begin
            acc_p0 <= acc_p0 + ACC_W'(prod);
            idx_p0 <= idx_p0 + AW'(1);
          end
        end
        S_FINISH: begin
          value_p1 <= saturate(activate(round_shift(sum)));
          vld_p1   <= 1'b1;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            vld_p1 <= 1'b0;
            acc_p0 <= '0;
            idx_p0 <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q_neuron.sv
// Bench for q_neuron: two instances (RELU off / on) see identical stimulus;
// expected results are queued as samples are driven and popped on output.
module tb_q_neuron;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int F  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  q_neuron_if #(.N_INPUTS(N), .DATA_W(DW)) nif ();
  q_neuron_if #(.N_INPUTS(N), .DATA_W(DW)) nif_r ();

  q_neuron #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(F), .RELU(0)) dut (
    .clk(clk), .reset(reset), .bus(nif)
  );
  q_neuron #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(F), .RELU(1)) dut_r (
    .clk(clk), .reset(reset), .bus(nif_r)
  );

  assign nif_r.in_valid  = nif.in_valid;
  assign nif_r.in_data   = nif.in_data;
  assign nif_r.w_we      = nif.w_we;
  assign nif_r.w_addr    = nif.w_addr;
  assign nif_r.w_data    = nif.w_data;
  assign nif_r.out_ready = nif.out_ready;

  int checks = 0;
  int failures = 0;

  int mw [N+1];
  longint acc_m;
  int n_m;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  logic [7:0] v0, v1, e0, e1, held;
  bit got;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input longint acc, input int bias, input bit relu);
    longint s;
    s = acc + (longint'(bias) <<< F) + (longint'(1) <<< (F - 1));
    s = s >>> F;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  task automatic send(input logic [7:0] d, input int gap, input bit we, input int wa, input int wd);
    int b;
    nif.in_valid = 1'b0;
    repeat (gap) step();
    b = 0;
    while (!nif.in_ready && b < 50) begin
      step();
      b++;
    end
    checks++;
    if (!nif.in_ready) begin
      failures++;
      $display("FAIL send_wait in_ready=%0d required=1", nif.in_ready);
    end
    nif.in_valid = 1'b1;
    nif.in_data  = d;
    if (we) begin
      nif.w_we   = 1'b1;
      nif.w_addr = wa[2:0];
      nif.w_data = wd[7:0];
    end
    acc_m += longint'($signed(d)) * longint'(mw[n_m]);
    n_m++;
    step();
    nif.in_valid = 1'b0;
    nif.w_we     = 1'b0;
    if (we && wa <= N) mw[wa] = $signed(wd[7:0]);
    if (n_m == N) begin
      q0.push_back(model(acc_m, mw[N], 1'b0));
      q1.push_back(model(acc_m, mw[N], 1'b1));
      acc_m = 0;
      n_m = 0;
    end
  endtask

  task automatic write_w(input int a, input int d);
    nif.w_we   = 1'b1;
    nif.w_addr = a[2:0];
    nif.w_data = d[7:0];
    step();
    nif.w_we = 1'b0;
    if (a <= N) mw[a] = $signed(d[7:0]);
  endtask

  task automatic collect(output logic [7:0] r0, output logic [7:0] r1, output bit ok);
    int b;
    b = 0;
    while (!nif.out_valid && b < 50) begin
      step();
      b++;
    end
    ok = nif.out_valid;
    r0 = nif.value;
    r1 = nif_r.value;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (nif.out_valid !== 1'b0 || nif.value !== 8'h00 || nif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state out_valid=%b value=%h in_ready=%b required 0/00/1",
               nif.out_valid, nif.value, nif.in_ready);
    end
    checks++;
    if (nif_r.out_valid !== 1'b0 || nif_r.value !== 8'h00 || nif_r.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state_relu out_valid=%b value=%h in_ready=%b required 0/00/1",
               nif_r.out_valid, nif_r.value, nif_r.in_ready);
    end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) write_w(i, 8'h10);
    write_w(N, 8'h00);
    nif.out_ready = 1'b1;
    send(8'h10, 0, 0, 0, 0);
    send(8'h20, 0, 0, 0, 0);
    send(8'h08, 0, 0, 0, 0);
    send(8'hF0, 0, 0, 0, 0);
    checks++;
    if (nif.in_ready !== 1'b0 || nif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_finish in_ready=%b out_valid=%b required 0/0", nif.in_ready, nif.out_valid);
    end
    step();
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (nif.out_valid !== 1'b1 || nif.in_ready !== 1'b0 || nif.value !== e0) begin
      failures++;
      $display("FAIL basic_latency out_valid=%b in_ready=%b value=%h required 1/0/%h",
               nif.out_valid, nif.in_ready, nif.value, e0);
    end
    checks++;
    if (nif_r.value !== e1) begin
      failures++;
      $display("FAIL basic_relu value=%h required=%h", nif_r.value, e1);
    end
    step();
    checks++;
    if (nif.out_valid !== 1'b0 || nif.in_ready !== 1'b1 || nif.value !== e0) begin
      failures++;
      $display("FAIL basic_release out_valid=%b in_ready=%b value=%h required 0/1/%h",
               nif.out_valid, nif.in_ready, nif.value, e0);
    end
  endtask

  task automatic test_sat_relu();
    logic [7:0] pat [3];
    pat[0] = 8'h7F;
    pat[1] = 8'h80;
    pat[2] = 8'h00;
    for (int i = 0; i < N; i++) write_w(i, 8'h7F);
    for (int p = 0; p < 3; p++) begin
      if (p == 2) begin
        write_w(5, 8'h33);
        write_w(7, 8'h55);
        write_w(N, 8'h10);
      end
      for (int i = 0; i < N; i++) send(pat[p], 0, 0, 0, 0);
      collect(v0, v1, got);
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (!got || v0 !== e0) begin
        failures++;
        $display("FAIL sat_pattern%0d value=%h valid=%0d required=%h", p, v0, got, e0);
      end
      checks++;
      if (!got || v1 !== e1) begin
        failures++;
        $display("FAIL sat_relu_pattern%0d value=%h valid=%0d required=%h", p, v1, got, e1);
      end
      step();
    end
    write_w(N, 8'h00);
  endtask

  task automatic test_rounding();
    logic [7:0] first [3];
    first[0] = 8'h08;
    first[1] = 8'h07;
    first[2] = 8'hF8;
    write_w(0, 8'h01);
    for (int i = 1; i <= N; i++) write_w(i, 8'h00);
    for (int p = 0; p < 3; p++) begin
      send(first[p], 0, 0, 0, 0);
      for (int i = 1; i < N; i++) send(8'h00, 0, 0, 0, 0);
      collect(v0, v1, got);
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      checks++;
      if (!got || v0 !== e0 || v1 !== e1) begin
        failures++;
        $display("FAIL rounding%0d value=%h relu_value=%h valid=%0d required %h/%h",
                 p, v0, v1, got, e0, e1);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) write_w(i, 8'h10);
    nif.out_ready = 1'b0;
    send(8'h30, 0, 0, 0, 0);
    send(8'h10, 0, 0, 0, 0);
    send(8'hE0, 0, 0, 0, 0);
    send(8'h04, 0, 0, 0, 0);
    collect(v0, v1, got);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (!got || v0 !== e0 || v1 !== e1) begin
      failures++;
      $display("FAIL bp_result value=%h relu_value=%h valid=%0d required %h/%h", v0, v1, got, e0, e1);
    end
    held = e0;
    for (int c = 0; c < 5; c++) begin
      nif.in_valid = 1'b1;
      nif.in_data  = 8'h7F;
      step();
      checks++;
      if (nif.out_valid !== 1'b1 || nif.value !== held || nif.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d out_valid=%b value=%h in_ready=%b required 1/%h/0",
                 c, nif.out_valid, nif.value, nif.in_ready, held);
      end
    end
    nif.in_valid  = 1'b0;
    nif.out_ready = 1'b1;
    step();
    checks++;
    if (nif.out_valid !== 1'b0 || nif.in_ready !== 1'b1 || nif.value !== held) begin
      failures++;
      $display("FAIL bp_release out_valid=%b in_ready=%b value=%h required 0/1/%h",
               nif.out_valid, nif.in_ready, nif.value, held);
    end
    for (int i = 0; i < N; i++) send(8'h10, 0, 0, 0, 0);
    collect(v0, v1, got);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (!got || v0 !== e0 || v1 !== e1) begin
      failures++;
      $display("FAIL bp_next value=%h relu_value=%h valid=%0d required %h/%h", v0, v1, got, e0, e1);
    end
    step();
  endtask

  task automatic test_gapped_race();
    logic [7:0] basic [4];
    int gaps [4];
    basic[0] = 8'h10; basic[1] = 8'h20; basic[2] = 8'h08; basic[3] = 8'hF0;
    gaps[0] = 1; gaps[1] = 3; gaps[2] = 2; gaps[3] = 1;
    for (int i = 0; i < N; i++) send(basic[i], gaps[i], 0, 0, 0);
    collect(v0, v1, got);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (!got || v0 !== e0 || v1 !== e1) begin
      failures++;
      $display("FAIL gapped value=%h relu_value=%h valid=%0d required %h/%h", v0, v1, got, e0, e1);
    end
    step();
    for (int i = 0; i < N; i++) send(basic[i], 0, (i == 1), 1, 8'h20);
    collect(v0, v1, got);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (!got || v0 !== e0 || v1 !== e1) begin
      failures++;
      $display("FAIL write_race value=%h relu_value=%h valid=%0d required %h/%h", v0, v1, got, e0, e1);
    end
    step();
    for (int i = 0; i < N; i++) send(basic[i], 0, 0, 0, 0);
    collect(v0, v1, got);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (!got || v0 !== e0 || v1 !== e1) begin
      failures++;
      $display("FAIL new_weight value=%h relu_value=%h valid=%0d required %h/%h", v0, v1, got, e0, e1);
    end
    step();
  endtask

  task automatic test_reset_mid();
    send(8'h7F, 0, 0, 0, 0);
    send(8'h7F, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    checks++;
    if (nif.out_valid !== 1'b0 || nif.value !== 8'h00 || nif.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid out_valid=%b value=%h in_ready=%b required 0/00/1",
               nif.out_valid, nif.value, nif.in_ready);
    end
    acc_m = 0;
    n_m = 0;
    for (int i = 0; i <= N; i++) mw[i] = 0;
    step();
    step();
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < N; i++) write_w(i, 8'h10);
    write_w(N, 8'h08);
    send(8'h10, 0, 0, 0, 0);
    send(8'h20, 0, 0, 0, 0);
    send(8'h08, 0, 0, 0, 0);
    send(8'hF0, 0, 0, 0, 0);
    collect(v0, v1, got);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    checks++;
    if (!got || v0 !== e0 || v1 !== e1) begin
      failures++;
      $display("FAIL reset_fresh value=%h relu_value=%h valid=%0d required %h/%h", v0, v1, got, e0, e1);
    end
    step();
  endtask

  initial begin
    nif.in_valid  = 1'b0;
    nif.in_data   = '0;
    nif.w_we      = 1'b0;
    nif.w_addr    = '0;
    nif.w_data    = '0;
    nif.out_ready = 1'b1;
    acc_m = 0;
    n_m = 0;
    for (int i = 0; i <= N; i++) mw[i] = 0;
    test_reset();
    test_basic();
    test_sat_relu();
    test_rounding();
    test_backpressure();
    test_gapped_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/q_neuron.md
# q_neuron

Single sequential neuron for the micromind datapath. It consumes a stream of N_INPUTS signed Q-format samples over a valid/ready handshake and multiplies each sample by a stored weight, accumulating one product per accepted sample. After the last sample it adds a bias, rounds, optionally applies ReLU and saturates. The 8-bit `value` is presented on a valid/ready output handshake. It is the producer of the `value` bus that the neuron bench monitors.

## Interface
- `N_INPUTS`, 4, samples (and weights) per inference, ≥2
- `DATA_W`, 8, width of samples, weights, bias and `value`
- `FRAC_BITS`, 4, fractional bits of every DATA_W quantity (Q3.4 at defaults), ≥1
- `RELU`, 0, 1 clamps negative results to 0 before saturation

- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `in_valid` in 1: sample present
- `in_ready` out 1: block can accept a sample
- `in_data` in DATA_W: signed sample
- `w_we` in 1: weight/bias write strobe
- `w_addr` in clog2(N_INPUTS+1): 0..N_INPUTS-1 selects a weight, N_INPUTS selects the bias
- `w_data` in DATA_W: signed weight/bias
- `out_valid` out 1: `value` holds a result
- `out_ready` in 1: consumer takes result
- `value` out DATA_W: signed result, same Q format

## Operation
- FSM states: ACCUM (reset state), FINISH, OUT.
- ACCUM: `in_ready`=1. On accept (`in_valid & in_ready`): acc += in_data × weight[idx]; idx++. The accept at idx=N_INPUTS-1 goes to FINISH.
- FINISH (one cycle): `in_ready`=0. Register `value` = sat(act((acc + (bias <<< FRAC_BITS) + 2^(FRAC_BITS-1)) >>> FRAC_BITS)). Set `out_valid`. Go to OUT.
- OUT: `in_ready`=0. `value` and `out_valid` are held stable. On `out_ready`: `out_valid`←0, acc←0, idx←0, go to ACCUM.
- Arithmetic: product is 2·DATA_W signed with 2·FRAC_BITS fraction bits. acc width = 2·DATA_W + clog2(N_INPUTS+1), signed. It can never overflow. Rounding is half-up (add half LSB, then arithmetic shift).
- act: identity if RELU=0; max(x,0) if RELU=1.
- sat: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Weights/bias: register file with N_INPUTS+1 entries. A write takes effect at the edge it is sampled, in any state. A product computed on the same edge as a write to its weight uses the old weight. Writes to addresses > N_INPUTS are ignored.
- `in_valid` while `in_ready`=0 is ignored, not queued.

## Timing
- Reset values (asynchronous, immediate): `value`=0, `out_valid`=0, `in_ready`=1 (state ACCUM), acc=0, idx=0, all weights and bias=0.
- Reset mid-inference discards the partial accumulation and the stored weights. The first sample after release is treated as sample 0.
- Throughput in ACCUM: one sample per cycle.
- Latency: `out_valid` rises on the first edge after the edge that accepts the last sample.
- `in_ready` is combinational from state only. It does not depend on `in_valid`.
- Result handshake at edge t (`out_valid & out_ready`): `out_valid`=0 after t, `in_ready`=1 after t. A sample presented in the cycle after t is accepted as sample 0.
- Minimum inference period is N_INPUTS+2 cycles with `out_ready` tied high.
- `value` retains its last result after `out_valid` falls, until the next FINISH.

## Test plan
- **Basic sum.** Weights 0x10 (1.0) ×4, bias 0, inputs 0x10, 0x20, 0x08, 0xF0 on consecutive cycles, `out_ready`=1 → `out_valid` one cycle after the 4th accept, `value`=0x28 (2.5). `in_ready`=0 for exactly 2 cycles.
- **Saturation and ReLU.** Weights 0x7F, inputs 0x7F ×4 → `value`=0x7F. Inputs 0x80 ×4 → `value`=0x80 with RELU=0 and 0x00 with RELU=1. Bias 0x10 with all inputs 0 → `value`=0x10.
- **Rounding.** weight[0]=0x01, others 0, input 0x08 then three 0x00 → `value`=0x01. Input 0x07 instead → 0x00. Input 0xF8 → 0x00.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles after `out_valid` → `value` and `out_valid` stable, `in_ready`=0, and `in_valid` pulses are ignored. After `out_ready`, the next inference produces the correct independent result.
- **Gapped input and write race.** Insert `in_valid` gaps of 1–3 cycles → same result as the basic sum. Write weight[1]=0x20 on the same edge that sample 1 is accepted → that product uses the old weight. The following inference uses 0x20.
- **Reset mid-operation.** Assert `reset` after 2 accepts for 3 cycles → immediately `out_valid`=0, `value`=0, `in_ready`=1. With weights reloaded, 4 fresh samples give the correct result with no residue from before the reset.
